pipe_hazard_ctrl: RTL and testbench

// Sequences the 5-stage 8-bit pipeline: decides per cycle whether the PC, IF/ID, ID/EX and EX/MEM registers advance, hold, flush or

---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 94 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline stages and the register-control outputs back to them.
interface pipe_hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rd;
    logic        id_uses_rs;
    logic        id_uses_rd;
    logic        id_halt;
    logic        ex_memread;
    logic [2:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_we;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_we;
    logic        id_ex_bubble;
    logic        ex_mem_we;
    logic        done;
    logic        mem_err;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs, id_rd, id_uses_rs, id_uses_rd, id_halt, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
               done, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rd, id_uses_rs, id_uses_rd, id_halt, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
               done, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-cycle advance/hold/flush/bubble control for the 5-stage pipeline,
// with load-use stalls, branch flushes, data-memory wait timeout and halt drain.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {RUN, MEM_WAIT, DRAIN, HALTED, ERR} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [DW-1:0] drain_cnt;
    logic          mstall, lu, act, br, lus, hlt, drn, wait_last, stall_inc;

    assign mstall    = bus.mem_req & ~bus.mem_ready;
    assign lu        = bus.ex_memread & ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd)) |
                                         (bus.id_uses_rd & (bus.id_rd == bus.ex_rd)));
    // act marks a cycle where the normal branch/load-use/halt priority applies
    assign act       = ((state == RUN) & ~mstall) | ((state == MEM_WAIT) & bus.mem_ready);
    assign br        = act & bus.ex_branch_taken;
    assign lus       = act & ~bus.ex_branch_taken & lu;
    assign hlt       = act & ~bus.ex_branch_taken & ~lu & bus.id_halt;
    assign drn       = state == DRAIN;
    assign wait_last = wait_cnt == WW'(MEM_TIMEOUT - 1);

    assign bus.pc_we        = act & ~lus & ~hlt;
    assign bus.if_id_we     = act & ~lus;
    assign bus.if_id_flush  = br | hlt | drn;
    assign bus.id_ex_we     = act | drn;
    assign bus.id_ex_bubble = br | lus | drn;
    assign bus.ex_mem_we    = act | (drn & ~mstall);
    assign stall_inc        = ((state == RUN) | (state == MEM_WAIT)) & ~bus.pc_we & ~br;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            wait_cnt         <= '0;
            drain_cnt        <= '0;
            bus.done         <= 1'b0;
            bus.mem_err      <= 1'b0;
            bus.stall_cycles <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mstall) begin
                        wait_cnt <= WW'(1);
                        state    <= MEM_WAIT;
                    end else if (hlt) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        state    <= hlt ? DRAIN : RUN;
                        if (hlt) drain_cnt <= '0;
                    end else if (wait_last) begin
                        bus.mem_err <= 1'b1;
                        state       <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (mstall) begin
                        if (wait_last) begin
                            bus.mem_err <= 1'b1;
                            state       <= ERR;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt  <= '0;
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                            bus.done <= 1'b1;
                            state    <= HALTED;
                        end
                    end
                end
                default: ;
            endcase
            if (stall_inc && bus.stall_cycles != 16'hFFFF)
                bus.stall_cycles <= bus.stall_cycles + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven RUN-state vectors plus hand-written stall, timeout and drain sequences.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total = 0;
    int   exp_stall = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .DRAIN_CYCLES(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] rs, rd;
        logic       uses_rs, uses_rd, halt, memread;
        logic [2:0] ex_rd;
        logic       br, req, rdy;
        logic [5:0] en;
        int         inc;
    } vec_t;

    vec_t tbl [10];

    // enables packed as {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we}
    function automatic logic [5:0] en_now();
        return {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_we, bus.id_ex_bubble, bus.ex_mem_we};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        bus.id_rs = 0; bus.id_rd = 0; bus.id_uses_rs = 0; bus.id_uses_rd = 0; bus.id_halt = 0;
        bus.ex_memread = 0; bus.ex_rd = 0; bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110101, 0};
        tbl[1] = '{"lu_rs",       3, 0, 1, 0, 0, 1, 3, 0, 0, 0, 6'b000111, 1};
        tbl[2] = '{"no_uses",     3, 3, 0, 0, 0, 1, 3, 0, 0, 0, 6'b110101, 0};
        tbl[3] = '{"lu_rd",       0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 6'b000111, 1};
        tbl[4] = '{"rs_mismatch", 2, 0, 1, 0, 0, 1, 3, 0, 0, 0, 6'b110101, 0};
        tbl[5] = '{"not_load",    3, 0, 1, 0, 0, 0, 3, 0, 0, 0, 6'b110101, 0};
        tbl[6] = '{"branch",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111111, 0};
        tbl[7] = '{"br_lu_halt",  3, 0, 1, 0, 1, 1, 3, 1, 0, 0, 6'b111111, 0};
        tbl[8] = '{"mem_same_cy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b110101, 0};
        tbl[9] = '{"lu_r0",       0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 6'b000111, 1};

        idle();
        do_reset();
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.mem_err, 0);
        chk("rst_stall", bus.stall_cycles, 0);
        chk("rst_en", en_now(), 6'b110101);

        for (int i = 0; i < 10; i++) begin
            bus.id_rs = tbl[i].rs; bus.id_rd = tbl[i].rd;
            bus.id_uses_rs = tbl[i].uses_rs; bus.id_uses_rd = tbl[i].uses_rd;
            bus.id_halt = tbl[i].halt; bus.ex_memread = tbl[i].memread; bus.ex_rd = tbl[i].ex_rd;
            bus.ex_branch_taken = tbl[i].br; bus.mem_req = tbl[i].req; bus.mem_ready = tbl[i].rdy;
            @(negedge clk);
            chk(tbl[i].name, en_now(), tbl[i].en);
            exp_stall += tbl[i].inc;
            cyc();
        end
        idle();
        chk("tbl_stall", bus.stall_cycles, exp_stall);

        // 4-cycle memory wait then completion
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mwait_en", en_now(), 6'b000000);
            cyc();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("mwait_done_en", en_now(), 6'b110101);
        cyc();
        idle();
        exp_stall += 4;
        chk("mwait_stall", bus.stall_cycles, exp_stall);
        @(negedge clk);
        chk("mwait_back_run", en_now(), 6'b110101);
        cyc();

        // memory timeout
        do_reset();
        chk("rst2_stall", bus.stall_cycles, 0);
        bus.mem_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tmo_pending", bus.mem_err, 0);
            cyc();
        end
        chk("tmo_err", bus.mem_err, 1);
        chk("tmo_stall", bus.stall_cycles, 16);
        idle();
        cyc();
        cyc();
        chk("tmo_sticky", bus.mem_err, 1);
        chk("tmo_err_en", en_now(), 6'b000000);
        do_reset();
        chk("tmo_rst_err", bus.mem_err, 0);

        // halt drain with one memory-stalled drain cycle
        bus.id_halt = 1'b1;
        @(negedge clk);
        chk("halt_en", en_now(), 6'b011101);
        cyc();
        idle();
        bus.mem_req = 1'b1;
        @(negedge clk);
        chk("drain_mstall_en", en_now(), 6'b001110);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_en", en_now(), 6'b001111);
            chk("drain_not_done", bus.done, 0);
            cyc();
        end
        chk("done", bus.done, 1);
        chk("halted_en", en_now(), 6'b000000);
        bus.ex_branch_taken = 1'b1;
        cyc();
        chk("done_sticky", bus.done, 1);
        chk("halted_pc", bus.pc_we, 0);
        idle();

        // reset mid-drain
        do_reset();
        bus.id_halt = 1'b1;
        cyc();
        idle();
        cyc();
        do_reset();
        chk("middrain_done", bus.done, 0);
        chk("middrain_en", en_now(), 6'b110101);
        cyc();
        chk("middrain_run", en_now(), 6'b110101);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
